// File: rtl/aer_rate_encoder.sv
// AER rate encoder: buffers one pixel frame and rate-codes it into spike events
// on a 4-phase REQ/ACK AER bus, closing each time step with a time-step event.
module aer_rate_encoder #(
  parameter int unsigned N             = 784,
  parameter int unsigned M             = 10,
  parameter int unsigned DW            = 8,
  parameter logic [15:0] LFSR_SEED_RST = 16'hACE1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          PIX_WE,
  input  logic [M-1:0]  PIX_ADDR,
  input  logic [DW-1:0] PIX_DATA,
  input  logic          START,
  input  logic [7:0]    NUM_TSTEPS,
  input  logic          SEED_LD,
  input  logic [15:0]   SEED,
  output logic [M+1:0]  AERIN_ADDR,
  output logic          AERIN_REQ,
  input  logic          AERIN_ACK,
  output logic          BUSY,
  output logic          DONE,
  output logic [15:0]   SPIKE_CNT
);

  // Buffer address width; pixel indices wider than this are range-checked first.
  localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;
  localparam logic [M-1:0] LastIdx = M'(N - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StCmp,
    StTs,
    StWaitHi,
    StWaitLo,
    StFin
  } state_e;

  state_e         state_q;
  logic [M-1:0]   idx_q;
  logic [7:0]     step_q;
  logic [7:0]     tsteps_q;
  logic [15:0]    lfsr_q;
  logic           is_ts_q;
  logic           req_q;
  logic [M+1:0]   addr_q;
  logic           busy_q;
  logic           done_q;
  logic [15:0]    cnt_q;
  logic [DW-1:0]  rd_data_q;
  logic           ack_s1_q;
  logic           ack_s2_q;

  logic [DW-1:0]  pix_mem [N];
  logic           pix_wr_en;
  logic           lfsr_fb;
  logic [15:0]    lfsr_nxt;
  logic           fire;

  // Write gating: frame is frozen while encoding, out-of-range indices dropped.
  always_comb begin
    pix_wr_en = PIX_WE && !busy_q && (32'(PIX_ADDR) < N);
  end

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1 in right-shift form, plus the fire decision
  // taken against the pre-advance low byte.
  always_comb begin
    lfsr_fb  = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    lfsr_nxt = {lfsr_fb, lfsr_q[15:1]};
    fire     = 32'(rd_data_q) > 32'(lfsr_q[7:0]);
  end

  // Pixel buffer: single-port RAM, one-cycle read issued from the RD state; not reset.
  always_ff @(posedge CLK) begin
    if (pix_wr_en) begin
      pix_mem[PIX_ADDR[AW-1:0]] <= PIX_DATA;
    end
    if (state_q == StRd) begin
      rd_data_q <= pix_mem[idx_q[AW-1:0]];
    end
  end

  // Two-flop synchroniser for the asynchronous acknowledge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ack_s1_q <= 1'b0;
      ack_s2_q <= 1'b0;
    end else begin
      ack_s1_q <= AERIN_ACK;
      ack_s2_q <= ack_s1_q;
    end
  end

  // Encoder FSM with registered bus, status and counter outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      step_q   <= '0;
      tsteps_q <= '0;
      lfsr_q   <= LFSR_SEED_RST;
      is_ts_q  <= 1'b0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (SEED_LD && !busy_q) begin
        lfsr_q <= (SEED == 16'h0000) ? LFSR_SEED_RST : SEED;
      end
      unique case (state_q)
        StIdle: begin
          if (START) begin
            if (NUM_TSTEPS == 8'd0) begin
              done_q <= 1'b1;
            end else begin
              tsteps_q <= NUM_TSTEPS;
              idx_q    <= '0;
              step_q   <= '0;
              cnt_q    <= '0;
              busy_q   <= 1'b1;
              state_q  <= StRd;
            end
          end
        end
        StRd: begin
          state_q <= StCmp;
        end
        StCmp: begin
          // One LFSR advance per evaluated pixel, whether or not it fires.
          lfsr_q <= lfsr_nxt;
          if (fire) begin
            addr_q  <= {2'b00, idx_q};
            req_q   <= 1'b1;
            is_ts_q <= 1'b0;
            if (cnt_q != 16'hFFFF) begin
              cnt_q <= cnt_q + 16'd1;
            end
            state_q <= StWaitHi;
          end else if (idx_q != LastIdx) begin
            idx_q   <= idx_q + M'(1);
            state_q <= StRd;
          end else begin
            state_q <= StTs;
          end
        end
        StTs: begin
          addr_q  <= {2'b11, {M{1'b0}}};
          req_q   <= 1'b1;
          is_ts_q <= 1'b1;
          state_q <= StWaitHi;
        end
        StWaitHi: begin
          if (ack_s2_q) begin
            req_q   <= 1'b0;
            state_q <= StWaitLo;
          end
        end
        StWaitLo: begin
          if (!ack_s2_q) begin
            if (is_ts_q) begin
              step_q <= step_q + 8'd1;
              if (step_q + 8'd1 == tsteps_q) begin
                state_q <= StFin;
              end else begin
                idx_q   <= '0;
                state_q <= StRd;
              end
            end else if (idx_q == LastIdx) begin
              state_q <= StTs;
            end else begin
              idx_q   <= idx_q + M'(1);
              state_q <= StRd;
            end
          end
        end
        StFin: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign AERIN_ADDR = addr_q;
  assign AERIN_REQ  = req_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign SPIKE_CNT  = cnt_q;

endmodule

// File: tb/tb_aer_rate_encoder.sv
// Self-checking bench for aer_rate_encoder: randomized frames and seeds, a queue of
// expected AER events from a software frame/LFSR model, and a bus monitor.
module tb_aer_rate_encoder;

  localparam int unsigned N  = 24;
  localparam int unsigned M  = 10;
  localparam int unsigned DW = 8;
  localparam logic [15:0] SeedRst = 16'hACE1;
  localparam logic [11:0] TsAddr  = 12'hC00;

  logic          clk = 1'b0;
  logic          rst;
  logic          pix_we;
  logic [M-1:0]  pix_addr;
  logic [DW-1:0] pix_data;
  logic          start;
  logic [7:0]    num_tsteps;
  logic          seed_ld;
  logic [15:0]   seed;
  logic [M+1:0]  aer_addr;
  logic          aer_req;
  logic          aer_ack;
  logic          busy;
  logic          done;
  logic [15:0]   spike_cnt;

  logic ack_r = 1'b0;
  bit   loopback = 1'b1;
  int   ack_delay = 0;

  assign aer_ack = loopback ? aer_req : ack_r;

  always #5 clk = ~clk;

  aer_rate_encoder #(
    .N(N), .M(M), .DW(DW), .LFSR_SEED_RST(SeedRst)
  ) dut (
    .CLK(clk), .RST(rst), .PIX_WE(pix_we), .PIX_ADDR(pix_addr), .PIX_DATA(pix_data),
    .START(start), .NUM_TSTEPS(num_tsteps), .SEED_LD(seed_ld), .SEED(seed),
    .AERIN_ADDR(aer_addr), .AERIN_REQ(aer_req), .AERIN_ACK(aer_ack),
    .BUSY(busy), .DONE(done), .SPIKE_CNT(spike_cnt)
  );

  int          n_checks = 0;
  int          n_pass = 0;
  logic [11:0] exp_q[$];
  logic [7:0]  frame[N];
  logic [15:0] model_lfsr;
  int          exp_spikes;
  int          n_rises = 0;
  bit          aborting = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Model LFSR: shift right, new MSB = XOR of bits 0,2,3,5 (x^16+x^14+x^13+x^11+1).
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    int v;
    int b;
    v = int'(s);
    b = ((v >> 0) ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
    return 16'((v >> 1) | (b << 15));
  endfunction

  task automatic build_expected(input int t);
    exp_spikes = 0;
    for (int s = 0; s < t; s++) begin
      for (int p = 0; p < int'(N); p++) begin
        if (frame[p] > model_lfsr[7:0]) begin
          exp_q.push_back(12'(p));
          exp_spikes++;
        end
        model_lfsr = lfsr_step(model_lfsr);
      end
      exp_q.push_back(TsAddr);
    end
    if (exp_spikes > 65535) exp_spikes = 65535;
  endtask

  task automatic write_pix(input int i, input logic [7:0] v, input bit track);
    @(negedge clk);
    pix_we = 1'b1; pix_addr = M'(i); pix_data = v;
    @(negedge clk);
    pix_we = 1'b0;
    if (track && i < int'(N)) frame[i] = v;
  endtask

  task automatic load_seed(input logic [15:0] s);
    @(negedge clk);
    seed_ld = 1'b1; seed = s;
    @(negedge clk);
    seed_ld = 1'b0;
    model_lfsr = (s == 16'h0) ? SeedRst : s;
  endtask

  task automatic random_frame();
    for (int p = 0; p < int'(N); p++) write_pix(p, 8'($urandom_range(0, 255)), 1'b1);
  endtask

  task automatic run_frame(input string tag, input int t, input bit lb, input int dly,
                           input bit poke);
    int cyc;
    bit busy_ok;
    loopback = lb;
    ack_delay = lb ? 0 : dly;
    build_expected(t);
    @(negedge clk);
    start = 1'b1; num_tsteps = 8'(t);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_set"}, 32'(busy), 1);
    busy_ok = 1'b1;
    cyc = 0;
    while (!done && cyc < 20000) begin
      if (!busy) busy_ok = 1'b0;
      if (poke && cyc == 5) begin
        start = 1'b1; num_tsteps = 8'd7;
        pix_we = 1'b1; pix_addr = M'(3); pix_data = ~frame[3];
      end else begin
        start = 1'b0; pix_we = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; pix_we = 1'b0;
    check({tag, "_done_seen"}, 32'(done), 1);
    check({tag, "_busy_clr_at_done"}, 32'(busy), 0);
    check({tag, "_busy_held"}, 32'(busy_ok), 1);
    check({tag, "_spike_cnt"}, 32'(spike_cnt), 32'(exp_spikes));
    @(negedge clk);
    check({tag, "_done_single"}, 32'(done), 0);
    check({tag, "_events_left"}, 32'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  // Acknowledge responder used when not in loopback: ACK follows REQ after ack_delay edges.
  initial begin
    forever begin
      wait (aer_req);
      repeat (ack_delay) @(posedge clk);
      #2 ack_r = 1'b1;
      wait (!aer_req);
      repeat (ack_delay) @(posedge clk);
      #2 ack_r = 1'b0;
    end
  end

  // Bus monitor: pops the scoreboard on each REQ rise and checks handshake rules.
  bit          prev_req = 1'b0;
  logic [11:0] cap_addr;
  int          hi_cnt = 0;
  bit          stable = 1'b1;
  int          ack_low = 100;
  always @(negedge clk) begin
    if (aer_req && !prev_req) begin
      n_rises++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_event: got addr 0x%0h, expected no event", aer_addr);
      end else begin
        check("event_addr", 32'(aer_addr), 32'(exp_q.pop_front()));
      end
      check("req_rise_after_ack_low", 32'(ack_low >= 2), 1);
      cap_addr = aer_addr;
      hi_cnt = 1;
      stable = 1'b1;
    end else if (aer_req) begin
      hi_cnt++;
      if (aer_addr !== cap_addr) stable = 1'b0;
    end else if (prev_req && !aborting) begin
      check("addr_stable", 32'(stable), 1);
      check("req_high_cycles", 32'(hi_cnt), 32'(ack_delay + 3));
    end
    ack_low = aer_ack ? 0 : ack_low + 1;
    prev_req = aer_req;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int r;
    int cyc;
    rst = 1'b1; pix_we = 1'b0; pix_addr = '0; pix_data = '0; start = 1'b0;
    num_tsteps = '0; seed_ld = 1'b0; seed = '0;
    repeat (3) @(negedge clk);
    check("rst_req", 32'(aer_req), 0);
    check("rst_addr", 32'(aer_addr), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_spike_cnt", 32'(spike_cnt), 0);
    rst = 1'b0;
    model_lfsr = SeedRst;

    // All-zero frame: only time-step events.
    for (int p = 0; p < int'(N); p++) write_pix(p, 8'h00, 1'b1);
    run_frame("zero", 3, 1'b1, 0, 1'b0);

    // Single bright pixel 5 with the reset seed.
    write_pix(5, 8'hFF, 1'b1);
    load_seed(SeedRst);
    run_frame("pix5", 4, 1'b1, 0, 1'b0);

    // Zero time steps: immediate DONE, no events, never busy.
    r = n_rises;
    @(negedge clk);
    start = 1'b1; num_tsteps = 8'd0;
    @(negedge clk);
    start = 1'b0;
    check("t0_done", 32'(done), 1);
    check("t0_busy", 32'(busy), 0);
    @(negedge clk);
    check("t0_done_single", 32'(done), 0);
    check("t0_busy_after", 32'(busy), 0);
    repeat (5) @(negedge clk);
    check("t0_no_req", 32'(n_rises), 32'(r));

    // Slow acknowledge.
    random_frame();
    load_seed(16'($urandom_range(1, 65535)));
    run_frame("delay10", 2, 1'b0, 10, 1'b0);

    // Zero seed maps to the reset seed; START/PIX_WE poked while busy; out-of-range write.
    random_frame();
    write_pix(40, ~frame[8], 1'b0);
    load_seed(16'h0000);
    run_frame("poke", 3, 1'b1, 0, 1'b1);
    run_frame("poke_rerun", 2, 1'b1, 0, 1'b0);

    // Randomized frames, seeds, step counts and acknowledge latencies.
    for (int k = 0; k < 4; k++) begin
      random_frame();
      load_seed(16'($urandom()));
      run_frame("rand", int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), 1'b0);
    end

    // Reset in the middle of a handshake, then re-encode from the reset seed.
    random_frame();
    write_pix(0, 8'h00, 1'b1);
    loopback = 1'b0; ack_delay = 10;
    build_expected(2);
    @(negedge clk);
    start = 1'b1; num_tsteps = 8'd2;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!aer_req && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_mid_reached_req", 32'(aer_req), 1);
    @(negedge clk);
    aborting = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_req", 32'(aer_req), 0);
    check("rst_mid_busy", 32'(busy), 0);
    exp_q.delete();
    repeat (30) @(negedge clk);
    aborting = 1'b0;
    model_lfsr = SeedRst;
    run_frame("after_rst", 2, 1'b0, 2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
